multi_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 47 ++++
 rtl/timer_channel.sv | 68 ++++++
 rtl/multi_timer.sv | 91 +++++++++
 tb/tb_multi_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, TCTL bit layout and pack/unpack helpers for multi_timer
package timer_pkg;

    localparam int TCNT_OFS  = 0;
    localparam int TLIM_OFS  = 4;
    localparam int TCTL_OFS  = 8;
    localparam int TPRE_OFS  = 0;
    localparam int TSTAT_OFS = 4;

    localparam int RDY = 0;
    localparam int OVR = 2;
    localparam int RUN = 4;
    localparam int ONE = 5;
    localparam int IE  = 8;

    localparam logic [8:0] TCTL_RESET = 9'h010;

    typedef struct packed {
        logic ie;
        logic oneshot;
        logic run;
        logic overrun;
        logic ready;
    } tctl_t;

    function automatic tctl_t tctl_unpack(logic [8:0] v);
        tctl_t t;
        t.ready   = v[RDY];
        t.overrun = v[OVR];
        t.run     = v[RUN];
        t.oneshot = v[ONE];
        t.ie      = v[IE];
        return t;
    endfunction

    function automatic logic [8:0] tctl_pack(tctl_t t);
        logic [8:0] v;
        v      = '0;
        v[RDY] = t.ready;
        v[OVR] = t.overrun;
        v[RUN] = t.run;
        v[ONE] = t.oneshot;
        v[IE]  = t.ie;
        return v;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: TCNT/TLIM/TCTL state and wrap/ready/overrun logic
module timer_channel
    import timer_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            wr_cnt,
    input  logic            wr_lim,
    input  logic            wr_ctl,
    input  logic            rd_clr,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] cnt,
    output logic [BITS-1:0] lim,
    output logic [BITS-1:0] ctl,
    output logic            irq
);

    tctl_t ctl_q;
    logic  at_limit;
    logic  wrap_evt;

    // >= rather than == so a limit lowered below the current count still wraps
    assign at_limit = (lim != '0) && (cnt >= lim - BITS'(1));
    assign wrap_evt = tick && ctl_q.run && !wr_cnt && at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            lim   <= '0;
            ctl_q <= tctl_unpack(TCTL_RESET);
        end else begin
            if (wr_cnt)
                cnt <= wdata;
            else if (tick && ctl_q.run)
                cnt <= at_limit ? '0 : cnt + BITS'(1);

            if (wr_lim)
                lim <= wdata;

            if (wrap_evt)
                ctl_q.ready <= 1'b1;
            else if (rd_clr || (wr_ctl && !wdata[RDY]))
                ctl_q.ready <= 1'b0;

            if (wrap_evt && ctl_q.ready)
                ctl_q.overrun <= 1'b1;
            else if (wr_ctl && !wdata[OVR])
                ctl_q.overrun <= 1'b0;

            if (wrap_evt && ctl_q.oneshot)
                ctl_q.run <= 1'b0;
            else if (wr_ctl)
                ctl_q.run <= wdata[RUN];

            if (wr_ctl) begin
                ctl_q.oneshot <= wdata[ONE];
                ctl_q.ie      <= wdata[IE];
            end
        end
    end

    assign ctl = BITS'(tctl_pack(ctl_q));
    assign irq = ctl_q.ready && ctl_q.ie;

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - memory-mapped multi-channel timer: decode, shared prescaler, channels, read mux, irq
module multi_timer
    import timer_pkg::*;
#(
    parameter int              BITS      = 32,
    parameter logic [BITS-1:0] BASE      = 'hF0000020,
    parameter int              NUM_CH    = 4,
    parameter int              CH_STRIDE = 16,
    parameter int              PRE_BITS  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            irq
);

    localparam logic [BITS-1:0] GLOB = BASE + BITS'(NUM_CH * CH_STRIDE);

    logic [NUM_CH-1:0] hit_cnt;
    logic [NUM_CH-1:0] hit_lim;
    logic [NUM_CH-1:0] hit_ctl;
    logic [NUM_CH-1:0] ch_irq;
    logic [BITS-1:0]   cnt_q [NUM_CH];
    logic [BITS-1:0]   lim_q [NUM_CH];
    logic [BITS-1:0]   ctl_q [NUM_CH];

    logic                hit_tpre;
    logic                hit_tstat;
    logic [PRE_BITS-1:0] tpre;
    logic [PRE_BITS-1:0] pre_cnt;
    logic                tick;

    assign hit_tpre  = memAddr == GLOB + BITS'(TPRE_OFS);
    assign hit_tstat = memAddr == GLOB + BITS'(TSTAT_OFS);
    assign tick      = pre_cnt == tpre;

    // Writing TPRE restarts the divider so the new period begins cleanly
    always_ff @(posedge clk) begin
        if (reset) begin
            tpre    <= '0;
            pre_cnt <= '0;
        end else if (we && hit_tpre) begin
            tpre    <= dataBusIn[PRE_BITS-1:0];
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_BITS'(1);
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam logic [BITS-1:0] CH_BASE = BASE + BITS'(n * CH_STRIDE);

        assign hit_cnt[n] = memAddr == CH_BASE + BITS'(TCNT_OFS);
        assign hit_lim[n] = memAddr == CH_BASE + BITS'(TLIM_OFS);
        assign hit_ctl[n] = memAddr == CH_BASE + BITS'(TCTL_OFS);

        timer_channel #(.BITS(BITS)) u_ch (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .wr_cnt (we && hit_cnt[n]),
            .wr_lim (we && hit_lim[n]),
            .wr_ctl (we && hit_ctl[n]),
            .rd_clr (!we && hit_cnt[n]),
            .wdata  (dataBusIn),
            .cnt    (cnt_q[n]),
            .lim    (lim_q[n]),
            .ctl    (ctl_q[n]),
            .irq    (ch_irq[n])
        );
    end

    always_comb begin
        dataBusOut = '0;
        if (!we) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (hit_cnt[n]) dataBusOut = cnt_q[n];
                if (hit_lim[n]) dataBusOut = lim_q[n];
                if (hit_ctl[n]) dataBusOut = ctl_q[n];
            end
            if (hit_tpre)  dataBusOut = BITS'(tpre);
            if (hit_tstat) dataBusOut = BITS'(ch_irq);
        end
    end

    assign irq = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - self-checking bench for multi_timer: directed vectors plus randomized model comparison
module tb_multi_timer;

    localparam logic [31:0] BASE  = 32'hF0000020;
    localparam logic [31:0] TCNT0 = BASE + 0,  TLIM0 = BASE + 4,  TCTL0 = BASE + 8;
    localparam logic [31:0] TCNT1 = BASE + 16, TLIM1 = BASE + 20, TCTL1 = BASE + 24;
    localparam logic [31:0] TCNT2 = BASE + 32, TCTL2 = BASE + 40;
    localparam logic [31:0] TCNT3 = BASE + 48, TLIM3 = BASE + 52, TCTL3 = BASE + 56;
    localparam logic [31:0] TPRE  = BASE + 64, TSTAT = BASE + 68;

    logic        clk = 1'b0;
    logic        reset, we;
    logic [31:0] memAddr, dataBusIn, dataBusOut;
    logic        irq;

    multi_timer dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rd, exp_rd;
    logic        ir, exp_irq;

    // Reference model: plain per-channel variables updated once per clock
    logic [31:0] m_cnt [4];
    logic [31:0] m_lim [4];
    bit          m_rdy [4], m_ovr [4], m_run [4], m_one [4], m_ie [4];
    int          m_tpre, m_pre;

    function automatic logic [31:0] m_ctl(int c);
        return 32'(m_rdy[c]) + 32'(m_ovr[c]) * 4 + 32'(m_run[c]) * 16
             + 32'(m_one[c]) * 32 + 32'(m_ie[c]) * 256;
    endfunction

    function automatic logic m_irq();
        for (int c = 0; c < 4; c++) if (m_rdy[c] && m_ie[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(logic w, logic [31:0] a);
        logic [31:0] s;
        if (w) return 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (a == BASE + 16 * c)     return m_cnt[c];
            if (a == BASE + 16 * c + 4) return m_lim[c];
            if (a == BASE + 16 * c + 8) return m_ctl(c);
        end
        if (a == TPRE) return 32'(m_tpre);
        s = 0;
        for (int c = 0; c < 4; c++) if (m_rdy[c] && m_ie[c]) s += (32'h1 << c);
        if (a == TSTAT) return s;
        return 32'h0;
    endfunction

    task automatic m_step(logic r, logic w, logic [31:0] a, logic [31:0] d);
        bit tick, wrap, rd_hit, cw;
        if (r) begin
            for (int c = 0; c < 4; c++) begin
                m_cnt[c] = 0; m_lim[c] = 0;
                m_rdy[c] = 0; m_ovr[c] = 0; m_run[c] = 1; m_one[c] = 0; m_ie[c] = 0;
            end
            m_tpre = 0; m_pre = 0;
            return;
        end
        tick = (m_pre == m_tpre);
        for (int c = 0; c < 4; c++) begin
            wrap   = 0;
            rd_hit = !w && a == BASE + 16 * c;
            cw     = w && a == BASE + 16 * c + 8;
            if (w && a == BASE + 16 * c) begin
                m_cnt[c] = d;
            end else if (tick && m_run[c]) begin
                if (m_lim[c] != 0 && longint'(m_cnt[c]) + 1 >= longint'(m_lim[c])) begin
                    wrap = 1;
                    m_cnt[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (w && a == BASE + 16 * c + 4) m_lim[c] = d;
            if (wrap && m_rdy[c]) m_ovr[c] = 1;
            else if (cw && !d[2]) m_ovr[c] = 0;
            if (wrap) m_rdy[c] = 1;
            else if (rd_hit || (cw && !d[0])) m_rdy[c] = 0;
            if (wrap && m_one[c]) m_run[c] = 0;
            else if (cw) m_run[c] = d[4];
            if (cw) begin
                m_one[c] = d[5];
                m_ie[c]  = d[8];
            end
        end
        if (w && a == TPRE) begin
            m_tpre = int'(d[7:0]);
            m_pre  = 0;
        end else begin
            m_pre = tick ? 0 : m_pre + 1;
        end
    endtask

    // One bus cycle: drive, sample just before the edge, advance the model on the edge
    task automatic cyc(logic w, logic [31:0] a, logic [31:0] d, logic r);
        we = w; memAddr = a; dataBusIn = d; reset = r;
        #3;
        rd      = dataBusOut;
        ir      = irq;
        exp_rd  = m_read(w, a);
        exp_irq = m_irq();
        @(posedge clk);
        m_step(r, w, a, d);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        cyc(1'b1, a, d, 1'b0);
    endtask

    task automatic rdc(string nm, logic [31:0] a, logic [31:0] expv);
        cyc(1'b0, a, 32'h0, 1'b0);
        chk(nm, rd, expv);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tv[$];

    task automatic add(logic w, logic [31:0] a, logic [31:0] d, logic [31:0] e, logic ei);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.exp_rd = e; v.exp_irq = ei;
        tv.push_back(v);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        if (k < 16) return BASE + 16 * (k / 4) + 4 * (k % 4);
        if (k == 16) return TPRE;
        if (k == 17) return TSTAT;
        if (k == 18) return TPRE + 8;
        return $urandom;
    endfunction

    function automatic logic [31:0] rand_data(logic [31:0] a);
        logic [31:0] x;
        x = $urandom;
        if (a == TPRE) return (x & 32'hFFFFFF00) | 32'($urandom_range(0, 3));
        case (a[3:0])
            4'h0: return $urandom_range(0, 3) == 0 ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                                  : 32'($urandom_range(0, 10));
            4'h4: return 32'($urandom_range(0, 8));
            4'h8: return $urandom_range(0, 3) == 0 ? x : (x | 32'h10);
            default: return x;
        endcase
    endfunction

    initial begin
        we = 0; memAddr = 0; dataBusIn = 0; reset = 1;
        @(posedge clk); #1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // reset state, then test 1: limit 5 on channel 0
        add(0, TCTL0, 0, 32'h010, 0);
        add(0, TPRE,  0, 0, 0);
        add(0, TSTAT, 0, 0, 0);
        add(0, TLIM0, 0, 0, 0);
        add(0, TCNT0, 0, 4, 0);
        add(0, TPRE + 8, 0, 0, 0);
        add(1, TCTL0, 32'h000, 0, 0);
        add(1, TLIM0, 5, 0, 0);
        add(1, TCNT0, 0, 0, 0);
        add(1, TCTL0, 32'h110, 0, 0);
        add(0, TCNT0, 0, 0, 0);
        add(0, TCNT0, 0, 1, 0);
        add(0, TCNT0, 0, 2, 0);
        add(0, TCNT0, 0, 3, 0);
        add(0, TCNT0, 0, 4, 0);
        add(0, TCNT0, 0, 0, 1);
        add(0, TCTL0, 0, 32'h110, 0);
        for (int i = 0; i < tv.size(); i++) begin
            cyc(tv[i].w, tv[i].a, tv[i].d, 1'b0);
            chk($sformatf("vec%0d_rd", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), 32'(ir), 32'(tv[i].exp_irq));
        end

        // test 2: overrun on channel 1
        wr(TCTL0, 32'h000);
        wr(TCTL1, 32'h000);
        wr(TLIM1, 3);
        wr(TCNT1, 0);
        wr(TCTL1, 32'h010);
        idle(6);
        rdc("t2_ovr", TCTL1, 32'h015);
        chk("t2_irq", 32'(ir), 0);
        wr(TCTL1, 32'h010);
        rdc("t2_clr", TCTL1, 32'h010);

        // test 3: prescaler 3, free-running wrap on channel 2
        wr(TPRE, 3);
        wr(TCTL2, 32'h100);
        wr(TCNT2, 0);
        wr(TCTL2, 32'h110);
        rdc("t3_c0", TCNT2, 0);
        for (int i = 0; i < 4; i++) rdc($sformatf("t3_c1_%0d", i), TCNT2, 1);
        rdc("t3_c2", TCNT2, 2);
        wr(TCNT2, 32'hFFFFFFFF);
        idle(2);
        rdc("t3_ctl", TCTL2, 32'h110);
        chk("t3_irq", 32'(ir), 0);
        rdc("t3_wrap", TCNT2, 0);
        wr(TPRE, 0);

        // test 4: one-shot on channel 3
        wr(TCTL3, 32'h000);
        wr(TCNT3, 0);
        wr(TLIM3, 2);
        wr(TCTL3, 32'h030);
        idle(2);
        rdc("t4_ctl", TCTL3, 32'h021);
        for (int i = 0; i < 20; i++) begin
            cyc(0, TCNT3, 0, 0);
            if (rd !== 32'h0) chk($sformatf("t4_hold%0d", i), rd, 0);
        end
        chk("t4_hold_end", rd, 0);

        // test 5: CPU write to TCNT beats a wrapping tick
        wr(TCNT0, 4);
        wr(TCTL0, 32'h110);
        wr(TCNT0, 100);
        rdc("t5_cnt", TCNT0, 100);
        chk("t5_irq0", 32'(ir), 0);
        rdc("t5_ctl", TCTL0, 32'h111);
        chk("t5_irq1", 32'(ir), 1);

        // test 6: limit lowered below count, then reset mid-count
        wr(TLIM0, 20);
        wr(TCTL0, 32'h110);
        wr(TCNT0, 7);
        wr(TLIM0, 4);
        rdc("t6_cnt", TCNT0, 8);
        rdc("t6_ctl", TCTL0, 32'h111);
        chk("t6_irq", 32'(ir), 1);
        cyc(0, 0, 0, 1);
        rdc("t6_rst_cnt", TCNT0, 0);
        chk("t6_rst_irq", 32'(ir), 0);
        rdc("t6_rst_lim", TLIM0, 0);
        rdc("t6_rst_ctl", TCTL0, 32'h010);
        rdc("t6_rst_pre", TPRE, 0);
        rdc("t6_rst_ctl3", TCTL3, 32'h010);

        // randomized traffic against the model
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            logic        w, r;
            logic [31:0] a, d;
            a = rand_addr();
            w = ($urandom_range(0, 3) == 0);
            d = rand_data(a);
            r = ($urandom_range(0, 299) == 0);
            cyc(w, a, d, r);
            chk($sformatf("rnd%0d_rd@%h", i, a), rd, exp_rd);
            chk($sformatf("rnd%0d_irq", i), 32'(ir), 32'(exp_irq));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
